// File: rtl/button_event_controller.sv
// Pushbutton front end: sync, debounce, rise detect, pending events, fixed-priority valid/ready port.
// btn_raw -> btn_level 2+DEB_CYCLES cycles, event 1 cycle later; holds under backpressure; AUTO_REPEAT_EN adds hold repeats.
module button_event_controller #(
  parameter int unsigned N_BTN         = 4,
  parameter int unsigned DEB_CYCLES    = 100000,
  parameter int unsigned REPEAT_DELAY  = 50000000,
  parameter int unsigned REPEAT_PERIOD = 10000000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_BTN-1:0]         btn_raw,
  output logic [N_BTN-1:0]         btn_level,
  output logic                     evt_valid,
  output logic [$clog2(N_BTN)-1:0] evt_id,
  input  logic                     evt_ready,
  output logic                     overrun
);
  localparam int unsigned IW = $clog2(N_BTN);
  localparam int unsigned DW = $clog2(DEB_CYCLES);

  if (N_BTN < 2 || DEB_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 1) begin : g_bad_params
    $error("button_event_controller: illegal parameter values");
  end

  typedef enum logic {S_IDLE, S_VALID} state_t;
  state_t r_state, w_state_next;

  logic [N_BTN-1:0] r_sync1, r_sync2, r_level, r_pending;
  logic [DW-1:0]    r_deb_cnt [N_BTN];
  logic [N_BTN-1:0] w_deb_done, w_rise, w_set, w_take, w_pending_next;
  logic [IW-1:0]    r_evt_id, w_id_next, w_low_id;
  logic             r_overrun, w_overrun_next, w_load;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  // The rise is taken in the cycle the new level is accepted, so pending lands together with btn_level.
  always_comb begin
    for (int i = 0; i < N_BTN; i++) begin
      w_deb_done[i] = (r_sync2[i] != r_level[i]) && (r_deb_cnt[i] == DW'(DEB_CYCLES - 1));
    end
    w_rise = w_deb_done & r_sync2;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_level <= '0;
      for (int i = 0; i < N_BTN; i++) r_deb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        if (r_sync2[i] == r_level[i]) begin
          r_deb_cnt[i] <= '0;
        end else if (w_deb_done[i]) begin
          r_level[i]   <= ~r_level[i];
          r_deb_cnt[i] <= '0;
        end else begin
          r_deb_cnt[i] <= r_deb_cnt[i] + DW'(1);
        end
      end
    end
  end

`ifdef AUTO_REPEAT_EN
  localparam int unsigned HMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned HW   = $clog2(HMAX);

  logic [HW-1:0]    r_hold_cnt [N_BTN];
  logic [N_BTN-1:0] r_hold_rep, w_rep_fire;

  // First fire waits REPEAT_DELAY high cycles, later ones REPEAT_PERIOD.
  always_comb begin
    for (int i = 0; i < N_BTN; i++) begin
      w_rep_fire[i] = r_level[i] && (r_hold_cnt[i] ==
                      (r_hold_rep[i] ? HW'(REPEAT_PERIOD - 1) : HW'(REPEAT_DELAY - 1)));
    end
    w_set = w_rise | w_rep_fire;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold_rep <= '0;
      for (int i = 0; i < N_BTN; i++) r_hold_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        if (!r_level[i]) begin
          r_hold_cnt[i] <= '0;
          r_hold_rep[i] <= 1'b0;
        end else if (w_rep_fire[i]) begin
          r_hold_cnt[i] <= '0;
          r_hold_rep[i] <= 1'b1;
        end else begin
          r_hold_cnt[i] <= r_hold_cnt[i] + HW'(1);
        end
      end
    end
  end
`else
  always_comb w_set = w_rise;
`endif

  always_comb begin
    w_low_id = '0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (r_pending[i]) w_low_id = IW'(i);
    end
    w_load       = (r_state == S_IDLE) || evt_ready;
    w_state_next = r_state;
    w_id_next    = r_evt_id;
    w_take       = '0;
    if (w_load) begin
      if (|r_pending) begin
        w_state_next     = S_VALID;
        w_id_next        = w_low_id;
        w_take[w_low_id] = 1'b1;
      end else begin
        w_state_next = S_IDLE;
      end
    end
    // A new set on a bit being handed out this cycle is kept: set wins over take.
    w_pending_next = (r_pending & ~w_take) | w_set;
    w_overrun_next = |(w_set & r_pending & ~w_take);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_evt_id  <= '0;
      r_pending <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_evt_id  <= w_id_next;
      r_pending <= w_pending_next;
      r_overrun <= w_overrun_next;
    end
  end

  assign btn_level = r_level;
  assign evt_valid = (r_state == S_VALID);
  assign evt_id    = r_evt_id;
  assign overrun   = r_overrun;
endmodule
